// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE PIO data-register transfer engine.
package ide_pkg;

  localparam int SECTOR_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_XFER = 3'd2,
    ST_WR_XFER = 3'd3,
    ST_WR_WAIT = 3'd4
  } xfer_state_e;

  // A sector count of zero is the ATA encoding for 256 sectors.
  function automatic logic [8:0] load_count(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

endpackage

// File: rtl/ide_edge_det.sv
// Rising-edge detector for the host data-register strobe, advanced only on clk_en.
module ide_edge_det (
  input  logic clk,
  input  logic clk_en,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset) prev <= 1'b0;
      else       prev <= in;
    end
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/ide_pio_xfer.sv
// IDE PIO sector transfer engine between the host data register and a sector FIFO.
// Optional interrupt generation is enabled with the IDE_PIO_IRQ_EN macro.
module ide_pio_xfer
  import ide_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        cmd_read,
  input  logic        cmd_write,
  input  logic        cmd_abort,
  input  logic [7:0]  sector_count,
  input  logic        host_cs,
  input  logic        host_we,
  input  logic [15:0] host_din,
  output logic [15:0] host_dout,
  output logic        fifo_rd,
  output logic        fifo_wr,
  output logic [15:0] fifo_din,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        bsy,
  output logic        drq,
  output logic        irq,
  input  logic        irq_ack,
  output logic        done,
  output logic [8:0]  sectors_left,
  output logic [2:0]  fsm_state
);

  xfer_state_e state, state_n;
  logic [7:0]  word_cnt;
  logic        access, last_word;
  logic        load, clr, rd_acc, wr_acc, dec, irq_set, done_set;

  ide_edge_det u_cs_edge (
    .clk    (clk),
    .clk_en (clk_en),
    .reset  (reset),
    .in     (host_cs),
    .rise   (access)
  );

  assign last_word = (word_cnt == 8'(SECTOR_WORDS - 1));

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    clr      = 1'b0;
    rd_acc   = 1'b0;
    wr_acc   = 1'b0;
    dec      = 1'b0;
    irq_set  = 1'b0;
    done_set = 1'b0;
    // Abort outranks every command and any host access in the same cycle.
    if (cmd_abort) begin
      state_n = ST_IDLE;
      clr     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_read) begin
            state_n = ST_RD_WAIT;
            load    = 1'b1;
          end else if (cmd_write) begin
            state_n = ST_WR_XFER;
            load    = 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (fifo_full) begin
            state_n = ST_RD_XFER;
            irq_set = 1'b1;
          end
        end
        ST_RD_XFER: begin
          if (access && !host_we) begin
            rd_acc = 1'b1;
            if (last_word) begin
              dec = 1'b1;
              if (sectors_left == 9'd1) begin
                state_n  = ST_IDLE;
                done_set = 1'b1;
              end else begin
                state_n = ST_RD_WAIT;
              end
            end
          end
        end
        ST_WR_XFER: begin
          if (access && host_we) begin
            wr_acc = 1'b1;
            if (last_word) state_n = ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (fifo_empty) begin
            dec     = 1'b1;
            irq_set = 1'b1;
            if (sectors_left == 9'd1) begin
              state_n  = ST_IDLE;
              done_set = 1'b1;
            end else begin
              state_n = ST_WR_XFER;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FIFO strobes are registered so each lasts exactly one enabled cycle;
  // read data is captured at the edge that ends the fifo_rd pulse.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset) begin
        state        <= ST_IDLE;
        word_cnt     <= 8'd0;
        sectors_left <= 9'd0;
        fifo_rd      <= 1'b0;
        fifo_wr      <= 1'b0;
        fifo_din     <= 16'd0;
        host_dout    <= 16'd0;
        done         <= 1'b0;
      end else begin
        state   <= state_n;
        fifo_rd <= rd_acc;
        fifo_wr <= wr_acc;
        done    <= done_set;
        if (wr_acc)  fifo_din  <= host_din;
        if (fifo_rd) host_dout <= fifo_dout;
        if (clr) begin
          word_cnt     <= 8'd0;
          sectors_left <= 9'd0;
        end else if (load) begin
          word_cnt     <= 8'd0;
          sectors_left <= load_count(sector_count);
        end else begin
          if (rd_acc || wr_acc) word_cnt <= word_cnt + 8'd1;
          if (dec) sectors_left <= sectors_left - 9'd1;
        end
      end
    end
  end

`ifdef IDE_PIO_IRQ_EN
  // A new interrupt takes priority over an acknowledge in the same cycle.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset)        irq <= 1'b0;
      else if (irq_set) irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq_ack ^ irq_set;
  assign irq        = 1'b0;
`endif

  assign bsy       = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
  assign drq       = (state == ST_RD_XFER) || (state == ST_WR_XFER);
  assign fsm_state = state;

endmodule

// File: tb/tb_ide_pio_xfer.sv
// Directed testbench for ide_pio_xfer: read, write, abort, reset and clock-enable cases.
module tb_ide_pio_xfer;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_XFER = 3'd2;
  localparam logic [2:0] S_WR_XFER = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

`ifdef IDE_PIO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk, reset, clk_en;
  logic        cmd_read, cmd_write, cmd_abort;
  logic [7:0]  sector_count;
  logic        host_cs, host_we;
  logic [15:0] host_din, host_dout;
  logic        fifo_rd, fifo_wr;
  logic [15:0] fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        bsy, drq, irq, irq_ack, done;
  logic [8:0]  sectors_left;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  ide_pio_xfer dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .cmd_read     (cmd_read),
    .cmd_write    (cmd_write),
    .cmd_abort    (cmd_abort),
    .sector_count (sector_count),
    .host_cs      (host_cs),
    .host_we      (host_we),
    .host_din     (host_din),
    .host_dout    (host_dout),
    .fifo_rd      (fifo_rd),
    .fifo_wr      (fifo_wr),
    .fifo_din     (fifo_din),
    .fifo_dout    (fifo_dout),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .bsy          (bsy),
    .drq          (drq),
    .irq          (irq),
    .irq_ack      (irq_ack),
    .done         (done),
    .sectors_left (sectors_left),
    .fsm_state    (fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    errors++;
    $error("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    done_cnt += int'(done);
    rd_cnt   += int'(fifo_rd);
    wr_cnt   += int'(fifo_wr);
    chk("rd_wr_exclusive", {31'd0, fifo_rd & fifo_wr}, 32'd0);
  endtask

  task automatic pulse_cmd(input logic rd, input logic wr, input logic [7:0] cnt);
    sector_count = cnt;
    cmd_read     = rd;
    cmd_write    = wr;
    step();
    cmd_read  = 1'b0;
    cmd_write = 1'b0;
  endtask

  task automatic abort();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [15:0] d);
    host_we  = we;
    host_din = d;
    host_cs  = 1'b1;
    step();
    host_cs = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1;
    cmd_read = 1'b0; cmd_write = 1'b0; cmd_abort = 1'b0;
    sector_count = 8'd0; host_cs = 1'b0; host_we = 1'b0; host_din = 16'd0;
    fifo_dout = 16'd0; fifo_full = 1'b0; fifo_empty = 1'b0; irq_ack = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_state", fsm_state, S_IDLE);
    chk("rst_bsy", bsy, 0);
    chk("rst_drq", drq, 0);
    chk("rst_irq", irq, 0);
    chk("rst_done", done, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_host_dout", host_dout, 0);
    chk("rst_fifo_din", fifo_din, 0);
    chk("rst_sectors_left", sectors_left, 0);
    reset = 1'b0;
    step();

    // Host access in IDLE is ignored
    rd_cnt = 0;
    host_access(1'b0, 16'h0);
    chk("idle_access_ignored", rd_cnt, 0);

    // Read one sector
    pulse_cmd(1'b1, 1'b0, 8'd1);
    chk("rd1_state_wait", fsm_state, S_RD_WAIT);
    chk("rd1_bsy", bsy, 1);
    chk("rd1_drq_low", drq, 0);
    chk("rd1_sectors_loaded", sectors_left, 1);
    rd_cnt = 0;
    host_access(1'b0, 16'h0);
    chk("rdwait_access_ignored", rd_cnt, 0);
    repeat (8) step();
    chk("rd1_still_busy", bsy, 1);
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    chk("rd1_state_xfer", fsm_state, S_RD_XFER);
    chk("rd1_drq", drq, 1);
    chk("rd1_bsy_low", bsy, 0);
    chk("rd1_irq_set", irq, IRQ_ON);
    repeat (2) step();
    chk("rd1_irq_held", irq, IRQ_ON);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("rd1_irq_ack", irq, 0);
    wr_cnt = 0;
    host_access(1'b1, 16'h1234);
    chk("rd1_wrong_dir", wr_cnt, 0);
    rd_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      fifo_dout = 16'hA000 ^ 16'(i);
      host_we = 1'b0;
      host_cs = 1'b1;
      step();
      chk("rd1_strobe", fifo_rd, 1);
      host_cs = 1'b0;
      step();
      chk("rd1_data", host_dout, 16'hA000 ^ 16'(i));
    end
    chk("rd1_rd_count", rd_cnt, 256);
    chk("rd1_done_once", done_cnt, 1);
    chk("rd1_state_idle", fsm_state, S_IDLE);
    chk("rd1_sectors_zero", sectors_left, 0);

    // sector_count 0 loads 256; set and ack together keeps irq
    pulse_cmd(1'b1, 1'b0, 8'd0);
    chk("cnt0_loads_256", sectors_left, 256);
    fifo_full = 1'b1;
    irq_ack   = 1'b1;
    step();
    fifo_full = 1'b0;
    irq_ack   = 1'b0;
    chk("irq_set_beats_ack", irq, IRQ_ON);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;

    // Abort at word 100 of a read, with a simultaneous host access
    rd_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 100; i++) host_access(1'b0, 16'h0);
    chk("abort_pre_reads", rd_cnt, 100);
    cmd_abort = 1'b1;
    host_we   = 1'b0;
    host_cs   = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("abort_state_idle", fsm_state, S_IDLE);
    chk("abort_sectors_clear", sectors_left, 0);
    host_cs = 1'b0;
    step();
    chk("abort_beats_access", rd_cnt, 100);
    host_access(1'b0, 16'h0);
    chk("abort_no_more_rd", rd_cnt, 100);
    chk("abort_no_done", done_cnt, 0);

    // Write two sectors
    done_cnt = 0;
    pulse_cmd(1'b0, 1'b1, 8'd2);
    chk("wr2_state_xfer", fsm_state, S_WR_XFER);
    chk("wr2_drq", drq, 1);
    chk("wr2_sectors_loaded", sectors_left, 2);
    for (int i = 0; i < 512; i++) begin
      host_we  = 1'b1;
      host_din = 16'(i);
      host_cs  = 1'b1;
      step();
      chk("wr2_strobe", fifo_wr, 1);
      chk("wr2_fifo_din", fifo_din, 32'(i));
      host_cs = 1'b0;
      step();
      if (i % 256 == 255) begin
        chk("wr2_state_wait", fsm_state, S_WR_WAIT);
        chk("wr2_bsy", bsy, 1);
        wr_cnt = 0;
        host_access(1'b1, 16'hFFFF);
        repeat (2) step();
        chk("wrwait_access_ignored", wr_cnt, 0);
        chk("wr2_still_wait", fsm_state, S_WR_WAIT);
        fifo_empty = 1'b1;
        step();
        fifo_empty = 1'b0;
        chk("wr2_irq_sector", irq, IRQ_ON);
        if (i == 255) begin
          chk("wr2_resume_xfer", fsm_state, S_WR_XFER);
          chk("wr2_sectors_one", sectors_left, 1);
          chk("wr2_no_early_done", done_cnt, 0);
          irq_ack = 1'b1;
          step();
          irq_ack = 1'b0;
          chk("wr2_irq_cleared", irq, 0);
        end else begin
          chk("wr2_state_idle", fsm_state, S_IDLE);
          chk("wr2_sectors_zero", sectors_left, 0);
          chk("wr2_done_pulse", done, 1);
          step();
          chk("wr2_done_single", done, 0);
        end
      end
    end
    chk("wr2_done_once", done_cnt, 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;

    // Reset during write word 50
    done_cnt = 0;
    pulse_cmd(1'b0, 1'b1, 8'd3);
    for (int i = 0; i < 50; i++) host_access(1'b1, 16'(i));
    host_we  = 1'b1;
    host_din = 16'h0032;
    host_cs  = 1'b1;
    step();
    chk("wr50_strobe", fifo_wr, 1);
    host_cs = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_state", fsm_state, S_IDLE);
    chk("midrst_flags", {bsy, drq, irq, done, fifo_rd, fifo_wr}, 0);
    chk("midrst_fifo_din", fifo_din, 0);
    chk("midrst_host_dout", host_dout, 0);
    chk("midrst_sectors", sectors_left, 0);
    chk("midrst_no_done", done_cnt, 0);

    // Held strobe counts once; word counter restarts from zero
    pulse_cmd(1'b0, 1'b1, 8'd1);
    wr_cnt   = 0;
    host_we  = 1'b1;
    host_din = 16'hBEEF;
    host_cs  = 1'b1;
    repeat (5) step();
    host_cs = 1'b0;
    step();
    chk("held_cs_one_strobe", wr_cnt, 1);
    chk("held_cs_data", fifo_din, 16'hBEEF);
    for (int i = 0; i < 254; i++) host_access(1'b1, 16'(i));
    chk("wordcnt_not_end", fsm_state, S_WR_XFER);
    host_access(1'b1, 16'h00FF);
    chk("wordcnt_restart_end", fsm_state, S_WR_WAIT);
    abort();
    chk("wr_abort_idle", fsm_state, S_IDLE);

    // clk_en low freezes everything, including abort
    pulse_cmd(1'b0, 1'b1, 8'd1);
    wr_cnt    = 0;
    clk_en    = 1'b0;
    cmd_abort = 1'b1;
    host_we   = 1'b1;
    host_cs   = 1'b1;
    repeat (3) step();
    chk("clken_state_hold", fsm_state, S_WR_XFER);
    chk("clken_no_strobe", wr_cnt, 0);
    chk("clken_sectors_hold", sectors_left, 1);
    cmd_abort = 1'b0;
    host_cs   = 1'b0;
    clk_en    = 1'b1;
    step();
    abort();

    // Simultaneous read and write commands: read wins
    pulse_cmd(1'b1, 1'b1, 8'd5);
    chk("both_cmd_read_wins", fsm_state, S_RD_WAIT);
    chk("both_cmd_sectors", sectors_left, 5);
    abort();
    chk("final_idle", fsm_state, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ide_pio_xfer.md
IDE_PIO_XFER -- requirements
Module: ide_pio_xfer

Interface
REQ-001 SHALL have port: clk  input  1  bus clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset; sampled on clk edges when clk_en=1.
REQ-003 SHALL have port: clk_en  input  1  clock enable; no state changes when 0.
REQ-004 SHALL have ports: cmd_read / cmd_write / cmd_abort  input  1 each  single-cycle command pulses from IO controller.
REQ-005 SHALL have port: sector_count  input  8  sectors to move, sampled with cmd_read/cmd_write; 0 means 256.
REQ-006 SHALL have ports: host_cs  input  1  data-register access strobe; host_we  input  1  1=write, 0=read.
REQ-007 SHALL have ports: host_din  input  16  host write data; host_dout  output  16  host read data.
REQ-008 SHALL have ports: fifo_rd / fifo_wr  output  1 each  FIFO strobes; fifo_din  output  16  write data to FIFO; fifo_dout  input  16  FIFO read data.
REQ-009 SHALL have ports: fifo_full / fifo_empty  input  1 each  FIFO sector-available / FIFO-drained flags.
REQ-010 SHALL have ports: bsy, drq, irq  output  1 each  ATA status bits; irq_ack  input  1  clears irq; done  output  1  one-cycle completion pulse; sectors_left  output  9  remaining sectors.

Function
REQ-011 SHALL implement states IDLE, RD_WAIT, RD_XFER, WR_XFER, WR_WAIT; bsy=1 in RD_WAIT/WR_WAIT, drq=1 in RD_XFER/WR_XFER, both 0 in IDLE.
REQ-012 SHALL detect host access as rising edge of host_cs across consecutive clk_en cycles; one access = one word.
REQ-013 IDLE: cmd_read -> RD_WAIT; cmd_write -> WR_XFER; sectors_left loaded with sector_count (0 -> 256), word counter cleared; cmd_read wins if both pulse together.
REQ-014 RD_WAIT: fifo_full=1 -> RD_XFER next cycle, irq set.
REQ-015 RD_XFER: each host read access SHALL pulse fifo_rd high for exactly one clk_en cycle and capture fifo_dout into host_dout in that same cycle (host_dout valid next cycle, held until next read).
REQ-016 WR_XFER: each host write access SHALL drive fifo_din=host_din and pulse fifo_wr high for exactly one clk_en cycle (FIFO pointer advances on fifo_wr falling edge).
REQ-017 Word counter 8 bits, wraps 255->0; 256th word of a sector ends the sector.
REQ-018 Read sector end: sectors_left-1; if result 0 -> IDLE with done pulse, else -> RD_WAIT.
REQ-019 Write sector end -> WR_WAIT; on fifo_empty=1: sectors_left-1; if 0 -> IDLE, irq set, done pulse; else -> WR_XFER, irq set.
REQ-020 Host accesses in IDLE, RD_WAIT, WR_WAIT, or with wrong direction SHALL be ignored (no FIFO strobe, no count).
REQ-021 irq SHALL stay 1 until irq_ack=1 or reset; set and ack in same cycle -> irq=1.
REQ-022 cmd_abort in any state SHALL force IDLE next clk_en cycle, clear word counter and sectors_left, no done pulse; abort beats a simultaneous host access.
REQ-023 fifo_rd and fifo_wr SHALL never be high in the same cycle.

Reset
REQ-024 reset SHALL dominate all inputs: state IDLE, bsy=drq=irq=done=fifo_rd=fifo_wr=0, host_dout=0, fifo_din=0, counters 0.
REQ-025 Reset mid-transfer SHALL discard progress; no done pulse.

Configuration
REQ-026 Macro IDE_PIO_IRQ_EN defined: irq/irq_ack behave per REQ-014/019/021.
REQ-027 IDE_PIO_IRQ_EN undefined: irq tied 0, irq_ack ignored, all other behaviour identical.

Structure
REQ-028 Package ide_pkg SHALL hold state enum type and constant SECTOR_WORDS=256.
REQ-029 Host-strobe edge detection SHALL be sub-module ide_edge_det (clk, clk_en, reset, in, rise).

Verification
REQ-030 Read 1 sector: cmd_read, count=1, fifo_full after 10 cycles -> bsy 1 then drq 1, 256 fifo_rd pulses, done once, sectors_left 0.
REQ-031 Write 2 sectors: 512 host writes of 0x0000..0x01FF -> fifo_din matches, WR_WAIT until fifo_empty, irq after each sector.
REQ-032 sector_count=0 -> sectors_left=256 loaded.
REQ-033 cmd_abort at word 100 of read -> IDLE next cycle, no done, further host_cs gives no fifo_rd.
REQ-034 Reset during WR_XFER word 50 -> all outputs 0; host_cs held high 5 cycles -> exactly one strobe.
